// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase codes, successor order and default dwell times shared with the controller
package traffic_pkg;

  typedef enum logic [1:0] {
    NS_GREEN  = 2'b00,
    NS_YELLOW = 2'b01,
    EW_GREEN  = 2'b10,
    EW_YELLOW = 2'b11
  } phase_e;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } mon_state_e;

  localparam int DEFAULT_GREEN_TICKS  = 5;
  localparam int DEFAULT_YELLOW_TICKS = 2;

  function automatic phase_e successor(input phase_e p);
    case (p)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      default:   return NS_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_lamp_decode.sv
// rtl/traffic_lamp_decode.sv - maps the six lamp lines onto a phase code plus legal/conflict flags
module traffic_lamp_decode
  import traffic_pkg::*;
(
  input  logic   ns_g,
  input  logic   ns_y,
  input  logic   ns_r,
  input  logic   ew_g,
  input  logic   ew_y,
  input  logic   ew_r,
  output phase_e phase,
  output logic   legal,
  output logic   conflict
);

  logic [5:0] lamps;

  assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};

  // Only these exact one-hot-per-direction patterns are legal; anything else reads as NS_GREEN/illegal.
  always_comb begin
    phase = NS_GREEN;
    legal = 1'b1;
    case (lamps)
      6'b100_001: phase = NS_GREEN;
      6'b010_001: phase = NS_YELLOW;
      6'b001_100: phase = EW_GREEN;
      6'b001_010: phase = EW_YELLOW;
      default:    legal = 1'b0;
    endcase
  end

  assign conflict = (ns_g | ns_y) & (ew_g | ew_y);

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase-order and dwell checker on the intersection lamp lines
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = DEFAULT_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEFAULT_YELLOW_TICKS,
  parameter int CYC_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ns_g,
  input  logic             ns_y,
  input  logic             ns_r,
  input  logic             ew_g,
  input  logic             ew_y,
  input  logic             ew_r,
  input  logic             err_clr,
  output phase_e           phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             err_conflict,
  output logic             err_illegal,
  output logic             err_sequence,
  output logic             err_timing,
  output logic             err_any,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int MAX_TICKS = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 2);
  localparam logic [CNT_W-1:0] GREEN_REQ  = CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0] YELLOW_REQ = CNT_W'(YELLOW_TICKS);

  mon_state_e       state, state_nxt;
  phase_e           dec_phase;
  logic             dec_legal, dec_conflict;
  logic [CNT_W-1:0] dwell, dwell_nxt, req, tick_cnt;
  logic [CYC_W-1:0] cycle_nxt;
  logic             changed;
  logic             set_seq, set_tim;
  logic             conflict_nxt, illegal_nxt, sequence_nxt, timing_nxt;

  traffic_lamp_decode u_decode (
    .ns_g     (ns_g),
    .ns_y     (ns_y),
    .ns_r     (ns_r),
    .ew_g     (ew_g),
    .ew_y     (ew_y),
    .ew_r     (ew_r),
    .phase    (dec_phase),
    .legal    (dec_legal),
    .conflict (dec_conflict)
  );

  // phase holds the last legal phase and phase_valid says the previous sample was legal,
  // so together they act as the "previous legal phase" for change detection.
  assign req      = (phase == NS_GREEN || phase == EW_GREEN) ? GREEN_REQ : YELLOW_REQ;
  assign tick_cnt = {{(CNT_W-1){1'b0}}, tick};
  assign changed  = dec_legal & phase_valid & (dec_phase != phase);
  assign locked   = (state == TRACK);

  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    cycle_nxt = cycle_count;
    set_seq   = 1'b0;
    set_tim   = 1'b0;
    case (state)
      SYNC: begin
        dwell_nxt = '0;
        if (changed) begin
          state_nxt = TRACK;
          dwell_nxt = tick_cnt;
        end
      end
      TRACK: begin
        if (!dec_legal) begin
          state_nxt = SYNC;
          dwell_nxt = '0;
        end else if (changed) begin
          set_seq   = (dec_phase != successor(phase));
          set_tim   = (dwell != req);
          dwell_nxt = tick_cnt;
          if (phase == EW_YELLOW && dec_phase == NS_GREEN) begin
            cycle_nxt = cycle_count + 1'b1;
          end
        end else if (tick) begin
          // Overrun is flagged as soon as it happens; the count parks one above the limit.
          set_tim = (dwell >= req);
          if (dwell <= req) begin
            dwell_nxt = dwell + 1'b1;
          end
        end
      end
      default: state_nxt = SYNC;
    endcase

    conflict_nxt = dec_conflict | (err_conflict & ~err_clr);
    illegal_nxt  = ~dec_legal   | (err_illegal  & ~err_clr);
    sequence_nxt = set_seq      | (err_sequence & ~err_clr);
    timing_nxt   = set_tim      | (err_timing   & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SYNC;
      dwell        <= '0;
      phase        <= NS_GREEN;
      phase_valid  <= 1'b0;
      err_conflict <= 1'b0;
      err_illegal  <= 1'b0;
      err_sequence <= 1'b0;
      err_timing   <= 1'b0;
      err_any      <= 1'b0;
      cycle_count  <= '0;
    end else begin
      state        <= state_nxt;
      dwell        <= dwell_nxt;
      if (dec_legal) begin
        phase <= dec_phase;
      end
      phase_valid  <= dec_legal;
      err_conflict <= conflict_nxt;
      err_illegal  <= illegal_nxt;
      err_sequence <= sequence_nxt;
      err_timing   <= timing_nxt;
      err_any      <= conflict_nxt | illegal_nxt | sequence_nxt | timing_nxt;
      cycle_count  <= cycle_nxt;
    end
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the lamp outputs of the intersection controller. Samples the six lamp lines and the shared 1 Hz `tick` and decodes the active phase. Tracks phase order and per-phase dwell in ticks, and raises sticky error flags for conflicting greens, illegal lamp patterns, out-of-order phases and wrong dwell times. Sits beside the controller on the same clock, with no feedback path into it.

## Interface
- `GREEN_TICKS`, 5: required tick count for each green phase
- `YELLOW_TICKS`, 2: required tick count for each yellow phase
- `CYC_W`, 16: width of `cycle_count`
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `tick`  in  1  one-cycle-per-second pulse, same signal the controller uses
- `ns_g`, `ns_y`, `ns_r`  in  1 each  north-south lamps
- `ew_g`, `ew_y`, `ew_r`  in  1 each  east-west lamps
- `err_clr`  in  1  synchronous clear of all sticky error flags
- `phase`  out  2  decoded phase: 00 NS_GREEN, 01 NS_YELLOW, 10 EW_GREEN, 11 EW_YELLOW
- `phase_valid`  out  1  lamp pattern is one of the four legal patterns
- `locked`  out  1  monitor is in TRACK
- `err_conflict`  out  1  sticky: both directions showing non-red
- `err_illegal`  out  1  sticky: any non-legal lamp pattern
- `err_sequence`  out  1  sticky: phase change to a non-successor phase
- `err_timing`  out  1  sticky: dwell differs from the required tick count
- `err_any`  out  1  OR of the four error flags
- `cycle_count`  out  CYC_W  completed full cycles; wraps at 2^CYC_W

## Operation
- **Legal patterns** (exactly these six bits): NS_GREEN = ns_g & ew_r; NS_YELLOW = ns_y & ew_r; EW_GREEN = ew_g & ns_r; EW_YELLOW = ew_y & ns_r.
- **Conflict:** (ns_g|ns_y) & (ew_g|ew_y). A conflicting pattern sets both `err_conflict` and `err_illegal`.
- **Successor order:** NS_GREEN→NS_YELLOW→EW_GREEN→EW_YELLOW→NS_GREEN.
- **FSM states:** SYNC, TRACK.
  - SYNC: the first dwell after reset is unmeasured. On the first change between two legal phases, go to TRACK and start counting the new phase.
  - TRACK, phase change (decoded phase ≠ previous legal phase):
    - set `err_sequence` if the new phase is not the successor;
    - set `err_timing` if the dwell count ≠ the required count for the completed phase;
    - restart the dwell count for the new phase.
  - TRACK, legal EW_YELLOW→NS_GREEN: increment `cycle_count`.
  - Any illegal pattern: set `err_illegal` and return to SYNC. Resync starts from the next legal→legal change.
- **Dwell count:** increments on each cycle where the pattern is legal, unchanged from the previous sample, and `tick`=1. On a change cycle, the count reloads to `tick` (0 or 1).
- **Early overrun:** in TRACK, if the count would exceed the required value while the phase is held, set `err_timing` immediately. The count saturates.
- **Count width:** clog2(max(GREEN_TICKS, YELLOW_TICKS)+2).
- **Error flags:** sticky until `err_clr` or reset. If `err_clr` and a new error occur in the same cycle, the set wins.
- `cycle_count` is not cleared by `err_clr`.

## Timing
- All outputs are registered, one cycle after the sampled lamps and `tick`.
- Reset values: `phase` 00, `phase_valid` 0, `locked` 0, all error flags 0, `err_any` 0, `cycle_count` 0. The FSM resets to SYNC with the dwell count at 0.
- `rst_n` is asserted asynchronously at any time and released synchronously through the bench. Asserting it mid-phase discards the partial dwell; there is no timing error for the first phase after release.
- The controller transitions on the edge after its final `tick`, so that tick is counted in the old phase.
- Back-to-back ticks are handled: a tick on a change cycle belongs to the new phase.

## Structure
- Shared package `traffic_pkg`:
  - phase codes NS_GREEN/NS_YELLOW/EW_GREEN/EW_YELLOW;
  - a successor function;
  - default GREEN_TICKS/YELLOW_TICKS, shared with the controller.
- One sub-module, `traffic_lamp_decode` (combinational): six lamp inputs → `phase`, `legal`, `conflict`.
- FSM, dwell counter and error registers live in the top module.

## Test plan
1. Controller instance and monitor reset together, `tick` every 4 clocks, run 3 full cycles → `locked`=1 after the first NS_GREEN→NS_YELLOW, `cycle_count`=3, `err_any`=0.
2. Force ns_g=1, ew_g=1, others 0 for one cycle → next cycle `err_conflict`=`err_illegal`=1, `phase_valid`=0, `locked`=0; legal restart relocks with no other errors.
3. While locked, hold NS_GREEN for a 6th tick → `err_timing`=1 one cycle after the 6th tick sample; leave NS_YELLOW after 1 tick → `err_timing` set on the change.
4. While locked, drive NS_GREEN→EW_GREEN directly → `err_sequence`=1, `cycle_count` unchanged.
5. `err_clr` pulsed alone → all flags 0 next cycle; `err_clr` coincident with a new conflict → `err_conflict` stays 1.
6. `rst_n` low mid-EW_GREEN → all outputs at reset values immediately. After release during EW_GREEN, the partial dwell raises no `err_timing`, and the monitor locks at the next phase change.
